hex_counter_display: RTL and testbench
======================================

Name: hex_counter_display

Overview:
- Parametrised N-digit counter shown on N seven-segment hex displays.
- Generalises the two-digit switch-driven hex display with:
  - an internal prescaler and up/down counting;
  - parallel load;
  - hexadecimal or decimal (BCD) mode;
  - leading-zero blanking and a wrap pulse.
- Sits between board switches/keys and the HEX displays of the DE-series board; also reusable as a timer/score display.

Parameters:
- DIGITS, 2, number of displays/nibbles; legal range 1..6.
- PRESCALE, 50000000, clock cycles per count step; must be >= 1 (1 = count every enabled cycle).

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- enable  input  1  prescaler and counting run while high.
- up  input  1  1 = count up, 0 = count down.
- load  input  1  synchronous parallel load request.
- load_value  input  4*DIGITS  value loaded when load=1, nibble i -> digit i.
- decimal  input  1  1 = BCD mode (digits 0-9), 0 = hex mode (0-F).
- blank_zeros  input  1  1 = leading-zero digits switched off.
- value  output  4*DIGITS  registered counter, nibble i = digit i.
- wrap  output  1  one-cycle pulse on counter wrap-around.
- hex  output  7*DIGITS  segments, hex[7i+6:7i] drives display i, active-low, bit order g..a.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - value=0, prescaler=0, wrap=0.
  - hex is decoded from value=0 as described under decode below.
- Prescaler:
  - Counts 0..PRESCALE-1 while enable=1, holds while enable=0.
  - tick=1 in the cycle where prescaler==PRESCALE-1 and enable=1; the prescaler returns to 0 on that edge.
- Priority at each rising edge, highest first:
  1. load: value <= load_value and prescaler <= 0.
     - In decimal mode, nibbles >9 are saturated to 9.
     - wrap=0.
  2. normalise: decimal=1 and any nibble of value >9: each such nibble <= 9.
     - No count is applied this cycle; the prescaler runs normally.
  3. tick: value steps by one according to up.
  4. otherwise value holds.
- Count arithmetic, per nibble, ripple carry/borrow from digit 0:
  - Hex mode: F+1 -> 0 with carry; 0-1 -> F with borrow.
  - Decimal mode: 9+1 -> 0 with carry; 0-1 -> 9 with borrow.
  - Maximum is 16^DIGITS-1 (hex) or 10^DIGITS-1 (decimal).
- wrap:
  - Registered; high for exactly one cycle after the edge where value went max->0 (up) or 0->max (down).
  - Low in every other cycle.
- Mode change mid-count takes effect at the next edge; no reset of the prescaler.
- Simultaneous load and tick: load wins and the tick is discarded.
- up changing between ticks affects only the next tick.
- Decode (combinational from value, so hex lags a count edge by 0 cycles after value updates):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
- Blanking:
  - With blank_zeros=1, digit i (i>=1) outputs 1111111 if it and all higher digits are 0.
  - Digit 0 is never blanked.
  - With blank_zeros=0 all digits are shown.
- Reset asserted mid-count clears immediately; the first tick after release is PRESCALE enabled cycles later.

Decomposition:
- Shared package hex_display_pkg:
  - typedef nibble_t (logic[3:0]) and seg7_t (logic[6:0]);
  - constant SEG_BLANK = 7'b1111111;
  - decode function or constant table for 0-F;
  - constants HEX_MAX_DIGIT = 4'hF and BCD_MAX_DIGIT = 4'd9.
- One sub-module seg7_decoder (nibble_t in, blank in, seg7_t out), instantiated DIGITS times in a generate loop.
- Prescaler, counter, wrap logic and blanking chain stay in the top module.

Test Plan:
- Reset, DIGITS=2, PRESCALE=4, blank_zeros=0 -> value=00, hex=1000000_1000000, wrap=0; assert reset_n=0 mid-count at value=37 -> value=00 before the next clock edge.
- enable=1, up=1, hex mode, count from 00 -> value increments every 4 cycles; after 256 ticks FF->00 with wrap high exactly one cycle.
- decimal=1, load 98, up=1 -> 99 then 00 with wrap pulse; then up=0 -> 00->99 with wrap pulse; digit 1 shows 0010000.
- decimal=1, load_value=8'hAF -> value=99; load 8'h3C in hex mode, then set decimal=1 -> next edge value=39, no count applied.
- load and tick in the same cycle, load_value=8'h50 -> value=50, prescaler=0, next tick 4 enabled cycles later; enable=0 for 10 cycles -> value and prescaler hold.
- blank_zeros=1, DIGITS=3, value=005 -> hex[20:7]=all 1s, digit 0=0010010; value=000 -> only digit 0 lit showing 1000000; value=105 -> all three digits lit.

Source files
------------

// File: rtl/hex_display_pkg.sv
// Shared types, constants and seven-segment encoding for the hex counter display.
package hex_display_pkg;

  typedef logic [3:0] nibble_t;
  typedef logic [6:0] seg7_t;

  localparam seg7_t   SEG_BLANK     = 7'b1111111;
  localparam nibble_t HEX_MAX_DIGIT = 4'hF;
  localparam nibble_t BCD_MAX_DIGIT = 4'd9;

  // Active-low segments, bit order g..a.
  function automatic seg7_t seg7_encode(input nibble_t d);
    seg7_t s;
    case (d)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// One seven-segment digit: nibble to active-low segments, with forced blanking.
module seg7_decoder
  import hex_display_pkg::*;
(
  input  nibble_t digit,
  input  logic    blank,
  output seg7_t   seg
);

  always_comb begin
    seg = blank ? SEG_BLANK : seg7_encode(digit);
  end

endmodule

// File: rtl/hex_counter_display.sv
// N-digit prescaled up/down counter (hex or BCD) with parallel load, wrap pulse
// and leading-zero-blanked seven-segment outputs.
module hex_counter_display
  import hex_display_pkg::*;
#(
  parameter int unsigned DIGITS   = 2,
  parameter int unsigned PRESCALE = 50000000
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  input  logic                  decimal,
  input  logic                  blank_zeros,
  output logic [4*DIGITS-1:0]   value,
  output logic                  wrap,
  output logic [7*DIGITS-1:0]   hex
);

  localparam int unsigned VW = 4 * DIGITS;
  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] prescaler;
  logic          tick;
  logic [VW-1:0] load_sat;
  logic [VW-1:0] normed;
  logic [VW-1:0] stepped;
  logic          needs_norm;
  logic          at_max;
  logic          at_zero;
  logic          carry;
  nibble_t       digit_max;
  nibble_t       nib;
  logic [DIGITS-1:0] blank_mask;
  logic          upper_zero;

  assign tick    = enable && (prescaler == PRE_LAST);
  assign at_zero = (value == '0);

  // Per-digit saturation, normalisation and ripple step in one pass.
  always_comb begin
    load_sat   = load_value;
    normed     = value;
    stepped    = value;
    needs_norm = 1'b0;
    at_max     = 1'b1;
    carry      = 1'b1;
    nib        = '0;
    digit_max  = decimal ? BCD_MAX_DIGIT : HEX_MAX_DIGIT;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      nib = load_value[4*i +: 4];
      if (decimal && (nib > BCD_MAX_DIGIT)) begin
        load_sat[4*i +: 4] = BCD_MAX_DIGIT;
      end
      nib = value[4*i +: 4];
      if (decimal && (nib > BCD_MAX_DIGIT)) begin
        normed[4*i +: 4] = BCD_MAX_DIGIT;
        needs_norm       = 1'b1;
      end
      if (nib != digit_max) begin
        at_max = 1'b0;
      end
      if (carry) begin
        if (up) begin
          if (nib == digit_max) begin
            stepped[4*i +: 4] = '0;
          end else begin
            stepped[4*i +: 4] = nib + 4'd1;
            carry             = 1'b0;
          end
        end else begin
          if (nib == '0) begin
            stepped[4*i +: 4] = digit_max;
          end else begin
            stepped[4*i +: 4] = nib - 4'd1;
            carry             = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      value     <= '0;
      prescaler <= '0;
      wrap      <= 1'b0;
    end else if (load) begin
      value     <= load_sat;
      prescaler <= '0;
      wrap      <= 1'b0;
    end else begin
      if (enable) begin
        prescaler <= tick ? '0 : prescaler + 1'b1;
      end
      // A pending normalisation swallows any tick in the same cycle.
      if (needs_norm) begin
        value <= normed;
        wrap  <= 1'b0;
      end else if (tick) begin
        value <= stepped;
        wrap  <= up ? at_max : at_zero;
      end else begin
        wrap  <= 1'b0;
      end
    end
  end

  // Walk from the most significant digit down; a digit blanks while everything above it is zero.
  always_comb begin
    blank_mask = '0;
    upper_zero = 1'b1;
    for (int unsigned j = 0; j < DIGITS; j++) begin
      upper_zero = upper_zero && (value[4*(DIGITS-1-j) +: 4] == '0);
      if ((DIGITS - 1 - j) != 0) begin
        blank_mask[DIGITS-1-j] = blank_zeros && upper_zero;
      end
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    seg7_decoder u_dec (
      .digit (value[4*g +: 4]),
      .blank (blank_mask[g]),
      .seg   (hex[7*g +: 7])
    );
  end

endmodule

// File: tb/tb_hex_counter_display.sv
// Randomised and directed bench for hex_counter_display against an arithmetic reference model.
module tb_hex_counter_display;

  localparam int D = 2;
  localparam int P = 4;
  localparam logic [6:0] SEG_TAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n, enable, up, load, decimal, blank_zeros;
  logic [7:0]  load_value;
  logic [7:0]  value;
  logic        wrap;
  logic [13:0] hex;

  logic        enable_b, up_b, load_b, decimal_b, blank_b;
  logic [11:0] load_value_b;
  logic [11:0] value_b;
  logic        wrap_b;
  logic [20:0] hex_b;

  hex_counter_display #(.DIGITS(D), .PRESCALE(P)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .up(up), .load(load),
    .load_value(load_value), .decimal(decimal), .blank_zeros(blank_zeros),
    .value(value), .wrap(wrap), .hex(hex));

  hex_counter_display #(.DIGITS(3), .PRESCALE(2)) dut_b (
    .clock(clock), .reset_n(reset_n), .enable(enable_b), .up(up_b), .load(load_b),
    .load_value(load_value_b), .decimal(decimal_b), .blank_zeros(blank_b),
    .value(value_b), .wrap(wrap_b), .hex(hex_b));

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;
  int wrap_seen = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: digits held as plain integers, counting done on the whole number.
  int m_dig [D];
  int m_pre;
  bit m_wrap;
  bit mt, mb;
  int mn, mbase, mmod, md;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < D; i++) m_dig[i] = 0;
      m_pre  = 0;
      m_wrap = 0;
    end else if (load) begin
      for (int i = 0; i < D; i++) begin
        md = int'(load_value[4*i +: 4]);
        if (decimal && md > 9) md = 9;
        m_dig[i] = md;
      end
      m_pre  = 0;
      m_wrap = 0;
    end else begin
      mt = enable && (m_pre == P - 1);
      if (enable) m_pre = (m_pre + 1) % P;
      mb = 0;
      if (decimal) begin
        for (int i = 0; i < D; i++) begin
          if (m_dig[i] > 9) begin
            m_dig[i] = 9;
            mb = 1;
          end
        end
      end
      if (mb) begin
        m_wrap = 0;
      end else if (mt) begin
        mbase = decimal ? 10 : 16;
        mmod  = mbase ** D;
        mn    = 0;
        for (int i = D - 1; i >= 0; i--) mn = mn * mbase + m_dig[i];
        if (up) begin
          m_wrap = (mn == mmod - 1);
          mn = (mn + 1) % mmod;
        end else begin
          m_wrap = (mn == 0);
          mn = (mn + mmod - 1) % mmod;
        end
        for (int i = 0; i < D; i++) begin
          m_dig[i] = mn % mbase;
          mn = mn / mbase;
        end
      end else begin
        m_wrap = 0;
      end
    end
  end

  function automatic logic [7:0] m_value();
    logic [7:0] v;
    for (int i = 0; i < D; i++) v[4*i +: 4] = 4'(m_dig[i]);
    return v;
  endfunction

  function automatic logic [13:0] m_hex(input bit bz);
    logic [13:0] h;
    bit zero_above;
    for (int i = 0; i < D; i++) begin
      zero_above = 1;
      for (int j = i; j < D; j++) if (m_dig[j] != 0) zero_above = 0;
      h[7*i +: 7] = (bz && i > 0 && zero_above) ? 7'b1111111 : SEG_TAB[m_dig[i]];
    end
    return h;
  endfunction

  always @(negedge clock) begin
    if (cmp_en) begin
      chk("value", 64'(value), 64'(m_value()));
      chk("wrap", 64'(wrap), 64'(m_wrap));
      chk("hex", 64'(hex), 64'(m_hex(blank_zeros)));
      if (wrap) wrap_seen++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1'b1;
    load_value = v;
    cyc(1);
    load = 1'b0;
  endtask

  initial begin
    reset_n = 0; enable = 0; up = 1; load = 0; decimal = 0; blank_zeros = 0; load_value = '0;
    enable_b = 0; up_b = 1; load_b = 0; decimal_b = 0; blank_b = 0; load_value_b = '0;
    cyc(3);
    chk("reset_value", 64'(value), 64'h00);
    chk("reset_hex", 64'(hex), 64'(14'b1000000_1000000));
    chk("reset_wrap", 64'(wrap), 64'h0);
    reset_n = 1;
    cmp_en = 1;

    // Hex up-count through FF -> 00
    enable = 1; up = 1; wrap_seen = 0;
    cyc(256 * 4 + 4);
    chk("hex_wrap_count", 64'(wrap_seen), 64'd1);
    chk("hex_after_257_ticks", 64'(value), 64'h01);

    // Asynchronous reset mid-count
    enable = 0;
    do_load(8'h37);
    cyc(2);
    chk("pre_reset_value", 64'(value), 64'h37);
    reset_n = 0;
    #1;
    chk("async_reset_value", 64'(value), 64'h00);
    chk("async_reset_hex", 64'(hex), 64'(14'b1000000_1000000));
    cyc(1);
    reset_n = 1; enable = 1;
    cyc(3);
    chk("no_tick_before_prescale", 64'(value), 64'h00);
    cyc(1);
    chk("first_tick_after_reset", 64'(value), 64'h01);

    // Decimal wrap up and down
    decimal = 1; up = 1;
    do_load(8'h98);
    chk("bcd_load_98", 64'(value), 64'h98);
    cyc(4);
    chk("bcd_99", 64'(value), 64'h99);
    cyc(4);
    chk("bcd_wrap_up_value", 64'(value), 64'h00);
    chk("bcd_wrap_up_pulse", 64'(wrap), 64'h1);
    up = 0;
    cyc(4);
    chk("bcd_wrap_down_value", 64'(value), 64'h99);
    chk("bcd_wrap_down_pulse", 64'(wrap), 64'h1);
    chk("bcd_digit1_nine", 64'(hex[13:7]), 64'(7'b0010000));

    // Load saturation and normalisation
    enable = 0;
    do_load(8'hAF);
    chk("bcd_load_sat", 64'(value), 64'h99);
    decimal = 0;
    do_load(8'h3C);
    chk("hex_load_3c", 64'(value), 64'h3C);
    decimal = 1;
    cyc(1);
    chk("normalise_39", 64'(value), 64'h39);

    // Load coinciding with a tick
    decimal = 0; up = 1; enable = 1;
    for (int k = 0; k < 8; k++) begin
      if (m_pre == P - 1) break;
      cyc(1);
    end
    do_load(8'h50);
    chk("load_beats_tick", 64'(value), 64'h50);
    cyc(3);
    chk("load_resets_prescaler", 64'(value), 64'h50);
    cyc(1);
    chk("tick_after_load", 64'(value), 64'h51);

    // Enable low holds everything
    cyc(2);
    enable = 0;
    cyc(10);
    chk("enable_hold", 64'(value), 64'h51);
    enable = 1;
    cyc(1);
    chk("prescaler_held", 64'(value), 64'h51);
    cyc(1);
    chk("resume_tick", 64'(value), 64'h52);

    // Randomised run
    for (int k = 0; k < 3000; k++) begin
      enable = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 49) == 0) up = ~up;
      if ($urandom_range(0, 99) == 0) decimal = ~decimal;
      if ($urandom_range(0, 9) == 0) blank_zeros = $urandom_range(0, 1);
      load = ($urandom_range(0, 39) == 0);
      load_value = 8'($urandom);
      reset_n = ($urandom_range(0, 499) != 0);
      cyc(1);
    end
    load = 0; reset_n = 1;
    cyc(2);

    // Three-digit blanking
    blank_b = 1;
    load_b = 1; load_value_b = 12'h005; cyc(1); load_b = 0;
    chk("blank_005_upper", 64'(hex_b[20:7]), 64'h3FFF);
    chk("blank_005_digit0", 64'(hex_b[6:0]), 64'(7'b0010010));
    load_b = 1; load_value_b = 12'h000; cyc(1); load_b = 0;
    chk("blank_000", 64'(hex_b), 64'({7'b1111111, 7'b1111111, 7'b1000000}));
    load_b = 1; load_value_b = 12'h105; cyc(1); load_b = 0;
    chk("blank_105", 64'(hex_b), 64'({7'b1111001, 7'b1000000, 7'b0010010}));
    load_b = 1; load_value_b = 12'h100; cyc(1); load_b = 0;
    chk("blank_100", 64'(hex_b), 64'({7'b1111001, 7'b1000000, 7'b1000000}));
    load_b = 1; load_value_b = 12'h005; blank_b = 0; cyc(1); load_b = 0;
    chk("noblank_005", 64'(hex_b), 64'({7'b1000000, 7'b1000000, 7'b0010010}));

    cmp_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
